// File: rtl/sdram_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// sdram_arbiter_pkg
// Shared definitions for the SDRAM request-port arbiter: FSM state encoding
// and the default address/data widths that match SdramCtrl's sdram_* port.
// -----------------------------------------------------------------------------
package sdram_arbiter_pkg;

  // Default widths, matching SdramCtrl's sdram_addr / sdram_data_w / sdram_data_r.
  localparam int DEF_AW = 24;
  localparam int DEF_DW = 16;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_RDWAIT = 2'd2
  } state_t;

endpackage

// File: rtl/sdram_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. Searches req upward starting at ptr and
// wrapping from NCLI-1 to 0; the first set bit wins.
// Ports:
//   req     in   NCLI   request vector
//   ptr     in   PW     search start position (0..NCLI-1)
//   any     out  1      at least one request is set
//   idx_oh  out  NCLI   one-hot winner (all zero when any=0)
//   idx_bin out  PW     binary winner index (zero when any=0)
// -----------------------------------------------------------------------------
module rr_pick
  import sdram_arbiter_pkg::*;
#(
  parameter int NCLI = 2,
  localparam int PW  = (NCLI > 1) ? $clog2(NCLI) : 1
) (
  input  logic [NCLI-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic            any,
  output logic [NCLI-1:0] idx_oh,
  output logic [PW-1:0]   idx_bin
);

  // Rotating priority search: the candidate at offset k from ptr only wins
  // if nothing closer to ptr has already been found.
  always_comb begin
    int  cand_s;
    logic hit_s;
    any     = 1'b0;
    idx_oh  = '0;
    idx_bin = '0;
    cand_s  = 0;
    hit_s   = 1'b0;
    for (int k = 0; k < NCLI; k++) begin
      cand_s         = (int'(ptr) + k) % NCLI;
      hit_s          = !any && req[cand_s];
      idx_oh[cand_s] = idx_oh[cand_s] | hit_s;
      idx_bin        = hit_s ? PW'(cand_s) : idx_bin;
      any            = any | hit_s;
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// -----------------------------------------------------------------------------
// sdram_arbiter
// Shares SdramCtrl's single request port between NCLI clients with round-robin
// arbitration and one access in flight. Read data is routed back to the client
// that issued the read; a read that never returns data is aborted after
// RD_TIMEOUT cycles and flagged on cli_err.
// Ports:
//   clk, reset                 clock (clk100) and synchronous active-high reset
//   cli_req/rh_wl/addr/data_w  per-client request level, 1=read, packed addr/data
//   cli_ack                    1-cycle pulse: command taken by SdramCtrl
//   cli_data_r, cli_data_r_en  shared read data, per-client valid pulse
//   cli_err                    1-cycle pulse: read timed out
//   busy                       high whenever the FSM is not IDLE
//   sdram_req/addr/rh_wl/data_w  registered command to SdramCtrl
//   sdram_ack                  command-taken pulse from SdramCtrl
//   sdram_data_r/_r_en         read data and valid pulse from SdramCtrl
// -----------------------------------------------------------------------------
module sdram_arbiter
  import sdram_arbiter_pkg::*;
#(
  parameter int NCLI       = 2,
  parameter int AW         = DEF_AW,
  parameter int DW         = DEF_DW,
  parameter int RD_TIMEOUT = 63
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NCLI-1:0]    cli_req,
  input  logic [NCLI-1:0]    cli_rh_wl,
  input  logic [NCLI*AW-1:0] cli_addr,
  input  logic [NCLI*DW-1:0] cli_data_w,
  output logic [NCLI-1:0]    cli_ack,
  output logic [DW-1:0]      cli_data_r,
  output logic [NCLI-1:0]    cli_data_r_en,
  output logic [NCLI-1:0]    cli_err,
  output logic              busy,
  output logic              sdram_req,
  input  logic              sdram_ack,
  output logic [AW-1:0]      sdram_addr,
  output logic              sdram_rh_wl,
  output logic [DW-1:0]      sdram_data_w,
  input  logic [DW-1:0]      sdram_data_r,
  input  logic              sdram_data_r_en
);

  localparam int PW = (NCLI > 1) ? $clog2(NCLI) : 1;
  localparam int TW = (RD_TIMEOUT > 0) ? $clog2(RD_TIMEOUT + 1) : 1;

  state_t          state_r;
  state_t          state_s;
  logic [PW-1:0]   grant_r;
  logic [NCLI-1:0] grant_oh_r;
  logic [PW-1:0]   rr_ptr_r;
  logic [TW-1:0]   timer_r;
  logic [NCLI-1:0] cli_err_r;
  logic            sdram_req_r;
  logic [AW-1:0]   sdram_addr_r;
  logic            sdram_rh_wl_r;
  logic [DW-1:0]   sdram_data_w_r;

  logic            pick_any_s;
  logic [NCLI-1:0] pick_oh_s;
  logic [PW-1:0]   pick_bin_s;
  logic            take_s;
  logic            acked_s;
  logic            rd_done_s;
  logic            rd_timeout_s;

  rr_pick #(.NCLI(NCLI)) u_rr_pick (
    .req     (cli_req),
    .ptr     (rr_ptr_r),
    .any     (pick_any_s),
    .idx_oh  (pick_oh_s),
    .idx_bin (pick_bin_s)
  );

  // Next-state logic and the single-cycle event strobes that drive the datapath.
  always_comb begin
    state_s      = state_r;
    take_s       = 1'b0;
    acked_s      = 1'b0;
    rd_done_s    = 1'b0;
    rd_timeout_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (pick_any_s) begin
          take_s  = 1'b1;
          state_s = ST_REQ;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (sdram_ack) begin
          acked_s = 1'b1;
          state_s = sdram_rh_wl_r ? ST_RDWAIT : ST_IDLE;
        end else begin
          state_s = ST_REQ;
        end
      end
      ST_RDWAIT: begin
        // Returned data takes priority over a timeout landing in the same cycle.
        if (sdram_data_r_en) begin
          rd_done_s = 1'b1;
          state_s   = ST_IDLE;
        end else if (timer_r == TW'(RD_TIMEOUT)) begin
          rd_timeout_s = 1'b1;
          state_s      = ST_IDLE;
        end else begin
          state_s = ST_RDWAIT;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Grant, round-robin pointer, latched command fields, read timer and error pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_r        <= '0;
      grant_oh_r     <= '0;
      rr_ptr_r       <= '0;
      timer_r        <= '0;
      cli_err_r      <= '0;
      sdram_req_r    <= 1'b0;
      sdram_addr_r   <= '0;
      sdram_rh_wl_r  <= 1'b1;
      sdram_data_w_r <= '0;
    end else begin
      if (take_s) begin
        grant_r        <= pick_bin_s;
        grant_oh_r     <= pick_oh_s;
        sdram_req_r    <= 1'b1;
        sdram_addr_r   <= cli_addr[pick_bin_s * AW +: AW];
        sdram_rh_wl_r  <= cli_rh_wl[pick_bin_s];
        sdram_data_w_r <= cli_data_w[pick_bin_s * DW +: DW];
      end
      if (acked_s) begin
        sdram_req_r <= 1'b0;
        rr_ptr_r    <= PW'((int'(grant_r) + 1) % NCLI);
      end
      // Timer only runs while waiting for read data; it restarts from 0 on entry.
      if (state_r == ST_RDWAIT) begin
        timer_r <= timer_r + TW'(1);
      end else begin
        timer_r <= '0;
      end
      cli_err_r <= rd_timeout_s ? grant_oh_r : '0;
    end
  end

  // Ack and data-valid are same-cycle with SdramCtrl's pulses; suppressing them
  // while reset is high keeps an aborted access from reporting completion.
  assign cli_ack       = {NCLI{acked_s & ~reset}} & grant_oh_r;
  assign cli_data_r_en = {NCLI{rd_done_s & ~reset}} & grant_oh_r;
  assign cli_data_r    = sdram_data_r;
  assign cli_err       = cli_err_r;
  assign busy          = (state_r != ST_IDLE);
  assign sdram_req     = sdram_req_r;
  assign sdram_addr    = sdram_addr_r;
  assign sdram_rh_wl   = sdram_rh_wl_r;
  assign sdram_data_w  = sdram_data_w_r;

endmodule

// File: tb/tb_sdram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sdram_arbiter
// Directed bench for sdram_arbiter. The stimulus thread pushes the expected
// client responses (acks, read data, errors) into queues; a negedge monitor
// pops and compares whenever the DUT pulses cli_ack, cli_data_r_en or cli_err.
// -----------------------------------------------------------------------------
module tb_sdram_arbiter;

  localparam int NCLI       = 2;
  localparam int AW         = 24;
  localparam int DW         = 16;
  localparam int RD_TIMEOUT = 63;

  logic              clk = 1'b0;
  logic              reset;
  logic [NCLI-1:0]    cli_req;
  logic [NCLI-1:0]    cli_rh_wl;
  logic [NCLI*AW-1:0] cli_addr;
  logic [NCLI*DW-1:0] cli_data_w;
  logic [NCLI-1:0]    cli_ack;
  logic [DW-1:0]      cli_data_r;
  logic [NCLI-1:0]    cli_data_r_en;
  logic [NCLI-1:0]    cli_err;
  logic              busy;
  logic              sdram_req;
  logic              sdram_ack;
  logic [AW-1:0]      sdram_addr;
  logic              sdram_rh_wl;
  logic [DW-1:0]      sdram_data_w;
  logic [DW-1:0]      sdram_data_r;
  logic              sdram_data_r_en;

  sdram_arbiter #(.NCLI(NCLI), .AW(AW), .DW(DW), .RD_TIMEOUT(RD_TIMEOUT)) dut (
    .clk             (clk),
    .reset           (reset),
    .cli_req         (cli_req),
    .cli_rh_wl       (cli_rh_wl),
    .cli_addr        (cli_addr),
    .cli_data_w      (cli_data_w),
    .cli_ack         (cli_ack),
    .cli_data_r      (cli_data_r),
    .cli_data_r_en   (cli_data_r_en),
    .cli_err         (cli_err),
    .busy            (busy),
    .sdram_req       (sdram_req),
    .sdram_ack       (sdram_ack),
    .sdram_addr      (sdram_addr),
    .sdram_rh_wl     (sdram_rh_wl),
    .sdram_data_w    (sdram_data_w),
    .sdram_data_r    (sdram_data_r),
    .sdram_data_r_en (sdram_data_r_en)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            cli;
    logic [AW-1:0] addr;
    logic          rh_wl;
    logic [DW-1:0] data;
  } ack_exp_t;

  typedef struct {
    int            cli;
    logic [DW-1:0] data;
  } rd_exp_t;

  ack_exp_t ack_q[$];
  rd_exp_t  rd_q[$];
  int       err_q[$];

  ack_exp_t mon_ack;
  rd_exp_t  mon_rd;
  int       mon_err;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every client-side pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (cli_ack != '0) begin
      if (ack_q.size() == 0) begin
        check("unexpected_cli_ack", 32'(cli_ack), 32'd0);
      end else begin
        mon_ack = ack_q.pop_front();
        check("ack_client", 32'(cli_ack), 32'(1 << mon_ack.cli));
        check("ack_sdram_req", 32'(sdram_req), 32'd1);
        check("ack_addr", 32'(sdram_addr), 32'(mon_ack.addr));
        check("ack_rh_wl", 32'(sdram_rh_wl), 32'(mon_ack.rh_wl));
        check("ack_data_w", 32'(sdram_data_w), 32'(mon_ack.data));
      end
    end
    if (cli_data_r_en != '0) begin
      if (rd_q.size() == 0) begin
        check("unexpected_cli_data_r_en", 32'(cli_data_r_en), 32'd0);
      end else begin
        mon_rd = rd_q.pop_front();
        check("rd_client", 32'(cli_data_r_en), 32'(1 << mon_rd.cli));
        check("rd_data", 32'(cli_data_r), 32'(mon_rd.data));
      end
    end
    if (cli_err != '0) begin
      if (err_q.size() == 0) begin
        check("unexpected_cli_err", 32'(cli_err), 32'd0);
      end else begin
        mon_err = err_q.pop_front();
        check("err_client", 32'(cli_err), 32'(1 << mon_err));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cli(input int c, input logic rh, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cli_req[c]              = 1'b1;
    cli_rh_wl[c]            = rh;
    cli_addr[c*AW +: AW]    = a;
    cli_data_w[c*DW +: DW]  = d;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_sdram_req"}, 32'(sdram_req), 32'd0);
    check({tag, "_sdram_addr"}, 32'(sdram_addr), 32'd0);
    check({tag, "_sdram_data_w"}, 32'(sdram_data_w), 32'd0);
    check({tag, "_sdram_rh_wl"}, 32'(sdram_rh_wl), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_cli_ack"}, 32'(cli_ack), 32'd0);
    check({tag, "_cli_data_r_en"}, 32'(cli_data_r_en), 32'd0);
    check({tag, "_cli_err"}, 32'(cli_err), 32'd0);
  endtask

  // Wait (bounded) until sdram_req is high; returns number of edges waited.
  task automatic wait_req(output int n);
    n = 0;
    while (!sdram_req && n < 20) begin
      tick();
      n++;
    end
    check("wait_sdram_req", 32'(sdram_req), 32'd1);
  endtask

  // One complete access from an idle arbiter.
  // rd_dly < 0 on a read means SdramCtrl never returns data (timeout path).
  task automatic do_access(input int c, input logic rh, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input int ack_dly,
                           input int rd_dly, input logic [DW-1:0] rd_data);
    int n;
    set_cli(c, rh, a, d);
    ack_q.push_back('{cli: c, addr: a, rh_wl: rh, data: d});
    check("req_low_cycle_n", 32'(sdram_req), 32'd0);
    tick();
    check("req_high_cycle_n1", 32'(sdram_req), 32'd1);
    check("busy_in_req", 32'(busy), 32'd1);
    for (int i = 0; i < ack_dly; i++) begin
      tick();
      check("req_held", 32'(sdram_req), 32'd1);
      check("addr_stable", 32'(sdram_addr), 32'(a));
      check("data_w_stable", 32'(sdram_data_w), 32'(d));
    end
    sdram_ack = 1'b1;
    tick();
    sdram_ack  = 1'b0;
    cli_req[c] = 1'b0;
    check("req_low_after_ack", 32'(sdram_req), 32'd0);
    if (rh) begin
      check("busy_in_rdwait", 32'(busy), 32'd1);
      if (rd_dly >= 1) begin
        for (int i = 1; i < rd_dly; i++) begin
          tick();
        end
        rd_q.push_back('{cli: c, data: rd_data});
        sdram_data_r    = rd_data;
        sdram_data_r_en = 1'b1;
        tick();
        sdram_data_r_en = 1'b0;
        check("idle_after_read", 32'(busy), 32'd0);
      end else begin
        err_q.push_back(c);
        n = 0;
        while (n < RD_TIMEOUT + 10) begin
          @(negedge clk);
          if (cli_err != '0) break;
          tick();
          n++;
        end
        check("err_latency", 32'(n), 32'(RD_TIMEOUT + 1));
        tick();
        check("idle_after_timeout", 32'(busy), 32'd0);
      end
    end else begin
      check("idle_after_write", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset           = 1'b1;
    cli_req         = '0;
    cli_rh_wl       = '0;
    cli_addr        = '0;
    cli_data_w      = '0;
    sdram_ack       = 1'b0;
    sdram_data_r    = '0;
    sdram_data_r_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check_reset_vals("reset");

    // 1: single write from client 0, ack after 3 cycles
    do_access(0, 1'b0, 24'h000123, 16'hBEEF, 3, 0, 16'h0000);

    // 2: read by client 1, data 5 cycles after the ack
    do_access(1, 1'b1, 24'hABCDEF, 16'h0000, 1, 5, 16'h5A5A);

    // 3: both clients hold req; pointer is 0 so grants go 0,1,0,1,0,1
    set_cli(0, 1'b0, 24'h000100, 16'h1000);
    set_cli(1, 1'b0, 24'h000200, 16'h2000);
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) ack_q.push_back('{cli: 0, addr: 24'h000100, rh_wl: 1'b0, data: 16'h1000});
      else            ack_q.push_back('{cli: 1, addr: 24'h000200, rh_wl: 1'b0, data: 16'h2000});
      wait_req(n);
      check("turnaround_edges", 32'(n), 32'd1);
      sdram_ack = 1'b1;
      tick();
      sdram_ack = 1'b0;
      if (i == 5) cli_req = '0;
    end
    tick();
    check("idle_after_rr", 32'(busy), 32'd0);

    // 4: read with no data returned, then a normal access
    do_access(0, 1'b1, 24'h000777, 16'h0000, 0, -1, 16'h0000);
    do_access(1, 1'b0, 24'h000888, 16'h1234, 0, 0, 16'h0000);

    // 5a: reset while in REQ, coinciding with an sdram_ack (must not ack)
    set_cli(1, 1'b0, 24'h003333, 16'h4444);
    tick();
    check("req_before_reset", 32'(sdram_req), 32'd1);
    reset     = 1'b1;
    sdram_ack = 1'b1;
    tick();
    reset     = 1'b0;
    sdram_ack = 1'b0;
    cli_req   = '0;
    check_reset_vals("rst_req");
    sdram_data_r    = 16'hDEAD;
    sdram_data_r_en = 1'b1;
    tick();
    sdram_data_r_en = 1'b0;
    check("stray_rd_after_rst_req", 32'(busy), 32'd0);

    // 5b: reset while in RDWAIT, coinciding with data_r_en (must not deliver)
    set_cli(0, 1'b1, 24'h005555, 16'h0000);
    ack_q.push_back('{cli: 0, addr: 24'h005555, rh_wl: 1'b1, data: 16'h0000});
    tick();
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    cli_req   = '0;
    tick();
    check("busy_rdwait_before_reset", 32'(busy), 32'd1);
    reset           = 1'b1;
    sdram_data_r_en = 1'b1;
    tick();
    reset           = 1'b0;
    sdram_data_r_en = 1'b0;
    check_reset_vals("rst_rdwait");
    sdram_data_r_en = 1'b1;
    tick();
    sdram_data_r_en = 1'b0;
    check("stray_rd_after_rst_rdwait", 32'(busy), 32'd0);

    // 6: stray pulses while idle, and read-data passthrough
    sdram_ack       = 1'b1;
    sdram_data_r_en = 1'b1;
    sdram_data_r    = 16'h1357;
    tick();
    sdram_ack       = 1'b0;
    sdram_data_r_en = 1'b0;
    check("stray_idle_busy", 32'(busy), 32'd0);
    check("stray_idle_req", 32'(sdram_req), 32'd0);
    check("data_r_passthrough", 32'(cli_data_r), 32'h1357);

    // Pointer was cleared by reset: with both requesting, client 0 goes first.
    set_cli(0, 1'b0, 24'h00AAAA, 16'h0A0A);
    set_cli(1, 1'b0, 24'h00BBBB, 16'h0B0B);
    ack_q.push_back('{cli: 0, addr: 24'h00AAAA, rh_wl: 1'b0, data: 16'h0A0A});
    ack_q.push_back('{cli: 1, addr: 24'h00BBBB, rh_wl: 1'b0, data: 16'h0B0B});
    for (int i = 0; i < 2; i++) begin
      wait_req(n);
      sdram_ack = 1'b1;
      tick();
      sdram_ack = 1'b0;
      if (i == 1) cli_req = '0;
    end
    repeat (3) tick();

    check("ack_queue_drained", 32'(ack_q.size()), 32'd0);
    check("rd_queue_drained", 32'(rd_q.size()), 32'd0);
    check("err_queue_drained", 32'(err_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
